// File: rtl/periph_rx_arbiter_pkg.sv
// Shared widths, types and FSM encoding for the peripheral RX arbiter.
package periph_rx_arbiter_pkg;

  localparam int unsigned usb_packet_width     = 32;
  localparam int unsigned periph_address_width = 3;
  localparam int unsigned periph_word_width    = usb_packet_width - periph_address_width;

  typedef logic [periph_word_width-1:0] periph_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StCapture,
    StWrite
  } arb_state_t;

endpackage

// File: rtl/periph_rx_arbiter_rr_priority_picker.sv
// Combinational find-first-set over req, starting at ptr and wrapping to index 0.
module rr_priority_picker #(
  parameter int unsigned NUM_PERIPHS = 8,
  parameter int unsigned IDX_W       = 3
) (
  input  logic [NUM_PERIPHS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   found,
  output logic [IDX_W-1:0]       idx
);

  always_comb begin
    int unsigned             cand;
    logic [NUM_PERIPHS-1:0]  req_sh;
    found  = 1'b0;
    idx    = '0;
    cand   = 0;
    req_sh = '0;
    for (int unsigned off = 0; off < NUM_PERIPHS; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NUM_PERIPHS) cand = cand - NUM_PERIPHS;
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Round-robin drain of peripheral RX FIFOs into the USB TX FIFO, tagging each word with
// its source address in the MSBs.
module periph_rx_arbiter
  import periph_rx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PERIPHS = 8,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic [NUM_PERIPHS*periph_word_width-1:0] periph_rx_data,
  input  logic [NUM_PERIPHS-1:0]                   periph_rx_empty,
  output logic [NUM_PERIPHS-1:0]                   periph_rx_rden,
  output logic [usb_packet_width-1:0]              usb_tx_data,
  output logic                                     usb_tx_wren,
  input  logic                                     usb_tx_full,
  output logic [periph_address_width-1:0]          grant_id,
  output logic                                     busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_t                      state_q;
  logic [periph_address_width-1:0] rr_ptr_q;
  logic [periph_address_width-1:0] grant_q;
  logic [CntW-1:0]                 burst_q;
  logic [usb_packet_width-1:0]     data_q;
  logic [NUM_PERIPHS-1:0]          rden_q;

  logic                            pick_found;
  logic [periph_address_width-1:0] pick_idx;
  logic [periph_address_width-1:0] ptr_next;
  logic [31:0]                     burst_next;
  logic [NUM_PERIPHS-1:0]          empty_sh;
  periph_word_t                    sel_word;

  rr_priority_picker #(
    .NUM_PERIPHS(NUM_PERIPHS),
    .IDX_W      (periph_address_width)
  ) u_picker (
    .req  (~periph_rx_empty),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign sel_word   = periph_word_t'(periph_rx_data >> (32'(grant_q) * periph_word_width));
  assign empty_sh   = periph_rx_empty >> grant_q;
  assign burst_next = 32'(burst_q) + 32'd1;
  assign ptr_next   = (32'(grant_q) + 32'd1 >= NUM_PERIPHS) ? '0
                                                           : grant_q + periph_address_width'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      data_q   <= '0;
      rden_q   <= '0;
    end else begin
      rden_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (enable && pick_found) begin
            grant_q <= pick_idx;
            rden_q  <= NUM_PERIPHS'(1) << pick_idx;
            state_q <= StRead;
          end
        end
        StRead: state_q <= StCapture;
        StCapture: begin
          data_q  <= {grant_q, sel_word};
          state_q <= StWrite;
        end
        StWrite: begin
          // While full, stay here with data_q frozen; wren is gated combinationally.
          if (!usb_tx_full) begin
            if (enable && burst_next < MAX_BURST && !empty_sh[0]) begin
              burst_q <= CntW'(burst_next);
              rden_q  <= NUM_PERIPHS'(1) << grant_q;
              state_q <= StRead;
            end else begin
              rr_ptr_q <= ptr_next;
              burst_q  <= '0;
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign periph_rx_rden = rden_q;
  assign usb_tx_data    = data_q;
  assign usb_tx_wren    = (state_q == StWrite) && !usb_tx_full;
  assign grant_id       = grant_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Bench for periph_rx_arbiter: FIFO/USB models, directed corner cases, table vectors, random rounds.
module tb_periph_rx_arbiter;
  import periph_rx_arbiter_pkg::*;

  localparam int unsigned NP = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned WW = 29;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NP*WW-1:0] periph_rx_data  = '0;
  logic [NP-1:0]    periph_rx_empty = '1;
  logic [NP-1:0]    periph_rx_rden;
  logic [31:0]      usb_tx_data;
  logic             usb_tx_wren;
  logic             usb_tx_full;
  logic [2:0]       grant_id;
  logic             busy;

  always #5 clk = ~clk;

  periph_rx_arbiter #(
    .NUM_PERIPHS(NP),
    .MAX_BURST  (MB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .periph_rx_data (periph_rx_data),
    .periph_rx_empty(periph_rx_empty),
    .periph_rx_rden (periph_rx_rden),
    .usb_tx_data    (usb_tx_data),
    .usb_tx_wren    (usb_tx_wren),
    .usb_tx_full    (usb_tx_full),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  int checks = 0;
  int passed = 0;

  logic [WW-1:0] fifo  [NP][$];
  logic [WW-1:0] exp_q [NP][$];
  logic [31:0]   out_log[$];
  int            exp_ord[$];

  typedef struct {
    logic [31:0] cnt;   // nibble i = words preloaded into FIFO i
    int          n;
    int          ord[16];
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // FIFO model (read latency 1) plus USB-side monitor; everything observed on negedge.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (periph_rx_rden[i]) begin
        check("rden_nonempty", 64'(fifo[i].size() != 0), 64'd1);
        if (fifo[i].size() != 0) periph_rx_data[i*WW +: WW] = fifo[i].pop_front();
      end
      periph_rx_empty[i] = (fifo[i].size() == 0);
    end
    if (periph_rx_rden != '0) check("rden_onehot", 64'($onehot(periph_rx_rden)), 64'd1);
    if (usb_tx_wren) begin
      check("wren_not_full", 64'(usb_tx_full), 64'd0);
      out_log.push_back(usb_tx_data);
    end
  end

  task automatic push(input int p, input logic [WW-1:0] w);
    fifo[p].push_back(w);
    exp_q[p].push_back(w);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    usb_tx_full = 1'b0;
    for (int i = 0; i < NP; i++) begin
      fifo[i].delete();
      exp_q[i].delete();
    end
    out_log.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic load(input logic [31:0] cnt);
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < int'(cnt[4*i +: 4]); j++) push(i, WW'($urandom));
    repeat (2) @(negedge clk);
    @(posedge clk); #1 enable = 1'b1;
  endtask

  task automatic wait_rden(input logic [NP-1:0] m);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (periph_rx_rden === m) break;
    end
    check("rden_seen", 64'(periph_rx_rden), 64'(m));
  endtask

  // Spec-level arbitration over preloaded counts: pick first non-empty from ptr, take up to MB.
  task automatic model_order(input logic [31:0] cnt, inout int ptr);
    int rem[NP];
    int p;
    int take;
    exp_ord.delete();
    for (int i = 0; i < NP; i++) rem[i] = int'(cnt[4*i +: 4]);
    forever begin
      p = -1;
      for (int off = 0; off < NP; off++)
        if (p < 0 && rem[(ptr + off) % NP] > 0) p = (ptr + off) % NP;
      if (p < 0) break;
      take = (rem[p] < MB) ? rem[p] : MB;
      repeat (take) exp_ord.push_back(p);
      rem[p] -= take;
      ptr = (p + 1) % NP;
    end
  endtask

  task automatic run_expect(input bit rand_full);
    int            n;
    int            src;
    logic [WW-1:0] ew;
    n = exp_ord.size();
    for (int c = 0; c < 3000 && out_log.size() < n; c++) begin
      @(posedge clk); #1;
      usb_tx_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    usb_tx_full = 1'b0;
    repeat (8) @(negedge clk);
    check("out_count", 64'(out_log.size()), 64'(n));
    for (int k = 0; k < n && k < out_log.size(); k++) begin
      src = exp_ord[k];
      ew  = (exp_q[src].size() > 0) ? exp_q[src].pop_front() : 'x;
      check("out_addr", 64'(out_log[k][31:29]), 64'(src));
      check("out_data", 64'(out_log[k][28:0]), 64'(ew));
    end
    check("idle_after", 64'(busy), 64'd0);
    out_log.delete();
    for (int i = 0; i < NP; i++) exp_q[i].delete();
  endtask

  int            ptr;
  logic [31:0]   rcnt;
  logic [WW-1:0] w0;

  initial begin
    vecs[0] = '{32'h1000_1001, 3, '{0, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{32'h0000_0160, 7, '{1, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{32'h1111_1111, 8, '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{32'h0205_0000, 7, '{4, 4, 4, 4, 6, 6, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{32'h5000_0001, 6, '{0, 7, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

    // Reset held with FIFO 2 non-empty and enable high.
    rst = 1'b0;
    enable = 1'b1;
    usb_tx_full = 1'b0;
    push(2, WW'($urandom));
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            64'({periph_rx_rden, usb_tx_wren, usb_tx_data, grant_id, busy}), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rden_release_cycle", 64'(periph_rx_rden), 64'd0);
    @(negedge clk);
    check("rden_after_reset", 64'(periph_rx_rden), 64'h04);
    exp_ord.delete(); exp_ord.push_back(2);
    run_expect(1'b0);

    // Single word latency from FIFO 5.
    enable = 1'b0;
    do_reset();
    push(5, 29'h0ABCDEF);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    check("idle_before_grant", 64'(periph_rx_rden), 64'd0);
    @(negedge clk);
    check("single_rden", 64'(periph_rx_rden), 64'h20);
    check("single_grant", 64'(grant_id), 64'd5);
    @(negedge clk);
    check("single_no_wren_capture", 64'(usb_tx_wren), 64'd0);
    @(negedge clk);
    check("single_wren", 64'(usb_tx_wren), 64'd1);
    check("single_data", 64'(usb_tx_data), 64'hA0ABCDEF);
    exp_ord.delete(); exp_ord.push_back(5);
    run_expect(1'b0);

    // Backpressure: full for 10 WRITE cycles.
    @(posedge clk); #1;
    usb_tx_full = 1'b1;
    w0 = WW'($urandom);
    push(3, w0);
    wait_rden(8'h08);
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", 64'({periph_rx_rden, usb_tx_wren, usb_tx_data}), 64'({8'h00, 1'b0, 3'd3, w0}));
    end
    @(posedge clk); #1 usb_tx_full = 1'b0;
    @(negedge clk);
    check("bp_wren_release", 64'(usb_tx_wren), 64'd1);
    @(negedge clk);
    check("bp_single_wren", 64'({usb_tx_wren, busy}), 64'd0);
    exp_ord.delete(); exp_ord.push_back(3);
    run_expect(1'b0);

    // Enable dropped during CAPTURE of a 3-word burst.
    @(posedge clk); #1;
    w0 = WW'($urandom);
    push(6, w0);
    push(6, WW'($urandom));
    push(6, WW'($urandom));
    wait_rden(8'h40);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop_wren", 64'({usb_tx_wren, usb_tx_data}), 64'({1'b1, 3'd6, w0}));
    @(negedge clk);
    check("drop_idle", 64'(busy), 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("drop_no_rden", 64'(periph_rx_rden), 64'd0);
    end
    check("drop_untouched", 64'(fifo[6].size()), 64'd2);
    exp_ord.delete(); exp_ord.push_back(6);
    run_expect(1'b0);

    // Table vectors, each from reset (rr_ptr = 0).
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load(vecs[v].cnt);
      exp_ord.delete();
      for (int k = 0; k < vecs[v].n; k++) exp_ord.push_back(vecs[v].ord[k]);
      run_expect(1'b0);
    end

    // Random preloaded rounds with random backpressure; rr_ptr carries across rounds.
    do_reset();
    ptr = 0;
    for (int r = 0; r < 6; r++) begin
      rcnt = '0;
      for (int i = 0; i < NP; i++) rcnt[4*i +: 4] = 4'($urandom_range(0, 5));
      if (rcnt == '0) rcnt[3:0] = 4'd2;
      model_order(rcnt, ptr);
      load(rcnt);
      run_expect(1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
